// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and types for the integer register file.
// Holds register count, address width, default data width and the address type.
package riscv_pkg;

  localparam int REG_COUNT    = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int XLEN_DEFAULT = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : riscv_pkg

// File: rtl/regfile_we_decode.sv
// One-hot write-select decoder: turns a register address plus enable into a
// REG_COUNT-wide select vector. The vector is all zeros whenever en is low.
module regfile_we_decode
  import riscv_pkg::*;
(
  input  logic                 en,
  input  reg_addr_t            addr,
  output logic [REG_COUNT-1:0] sel
);

  // Gating with an if keeps an unknown address from leaking into sel while disabled
  always_comb begin
    sel = '0;
    if (en) begin
      sel[addr] = 1'b1;
    end
  end

endmodule : regfile_we_decode

// File: rtl/register_file.sv
// 32 x XLEN register file, two combinational read ports, one synchronous write port.
// Optional same-cycle write-through forwarding is built when REGFILE_BYPASS_EN is defined.
module register_file
  import riscv_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            WE,
  input  logic [4:0]      A3,
  input  logic [XLEN-1:0] WD,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2
);

  logic [REG_COUNT-1:0] we_sel;
  logic [XLEN-1:0]      regs_q [REG_COUNT];
  logic [XLEN-1:0]      regs_d [REG_COUNT];

  regfile_we_decode u_we_decode (
    .en   (WE),
    .addr (reg_addr_t'(A3)),
    .sel  (we_sel)
  );

  // x0 is never loaded, so it holds the zero it takes on reset
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
      if (we_sel[i] && (i != 0)) begin
        regs_d[i] = WD;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= (i == 0) ? '0 : RESET_VAL;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;

  // Forward only a write that will really land: enabled, out of reset, not x0
  always_comb begin
    fwd_ok = WE && RESET && (A3 != 5'd0);
    RD1    = regs_q[A1];
    RD2    = regs_q[A2];
    if (fwd_ok && (A1 == A3)) begin
      RD1 = WD;
    end
    if (fwd_ok && (A2 == A3)) begin
      RD2 = WD;
    end
  end
`else
  always_comb begin
    RD1 = regs_q[A1];
    RD2 = regs_q[A2];
  end
`endif

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, write/read, x0,
// same-cycle read of the write target, reset/write collision and a full sweep.
module tb_register_file;

  localparam logic [31:0] RV = 32'h0BAD_F00D;

  logic        CLK;
  logic        RESET;
  logic        WE;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;

  int total = 0;
  int bad   = 0;

  register_file #(
    .XLEN      (32),
    .RESET_VAL (RV)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .WE    (WE),
    .A3    (A3),
    .WD    (WD),
    .A1    (A1),
    .A2    (A2),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                               input logic [4:0] a1, input logic [4:0] a2);
    WE = we;
    A3 = a3;
    WD = wd;
    A1 = a1;
    A2 = a2;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Mid-cycle reset assertion must show up on the read ports before any edge
    RESET = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    checkOutput("reset_rd1_x5", RD1, RV);
    checkOutput("reset_rd2_x31", RD2, RV);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
    checkOutput("reset_x0", RD1, 32'h0);
    checkOutput("reset_x1", RD2, RV);
    tick();
    RESET = 1'b1;

    // Basic write then read, all other registers untouched
    applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7);
    checkOutput("wr_x7_rd1", RD1, 32'hDEADBEEF);
    checkOutput("wr_x7_rd2", RD2, 32'hDEADBEEF);
    for (int i = 1; i < 32; i++) begin
      if (i != 7) begin
        applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
        checkOutput($sformatf("untouched_x%0d", i), RD1, RV);
      end
    end

    // Writes to x0 are dropped
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    checkOutput("x0_pre_edge", RD1, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("x0_rd1", RD1, 32'h0);
    checkOutput("x0_rd2", RD2, 32'h0);

    // Same-cycle read of the register being written
    applyStimulus(1'b1, 5'd12, 32'h00000011, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd12, 32'h00000055, 5'd12, 5'd12);
`ifdef REGFILE_BYPASS_EN
    checkOutput("same_cycle_rd1", RD1, 32'h00000055);
    checkOutput("same_cycle_rd2", RD2, 32'h00000055);
`else
    checkOutput("same_cycle_rd1", RD1, 32'h00000011);
    checkOutput("same_cycle_rd2", RD2, 32'h00000011);
`endif
    tick();
    applyStimulus(1'b0, 5'd12, 32'h0, 5'd12, 5'd7);
    checkOutput("after_edge_x12", RD1, 32'h00000055);
    checkOutput("after_edge_x7", RD2, 32'hDEADBEEF);

    // Writing x0 never forwards, even when the read address matches
    applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd12);
    checkOutput("no_fwd_x0", RD1, 32'h0);
    checkOutput("no_fwd_other", RD2, 32'h00000055);
    tick();

    // WE low leaves state alone
    applyStimulus(1'b0, 5'd7, 32'h12345678, 5'd7, 5'd12);
    tick();
    checkOutput("we0_x7", RD1, 32'hDEADBEEF);
    checkOutput("we0_x12", RD2, 32'h00000055);

    // Reset falling on the same edge as a write
    applyStimulus(1'b1, 5'd3, 32'h00000033, 5'd3, 5'd3);
    tick();
    checkOutput("pre_collide_x3", RD1, 32'h00000033);
    WD = 32'hA5A5A5A5;
    @(posedge CLK);
    RESET = 1'b0;
    #1;
    checkOutput("collide_x3", RD1, RV);
    applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd7);
    checkOutput("collide_x7", RD2, RV);
    checkOutput("collide_no_fwd", RD1, RV);
    tick();
    checkOutput("held_in_reset_x3", RD1, RV);
    RESET = 1'b1;
    tick();
    checkOutput("first_edge_write_x3", RD1, 32'hA5A5A5A5);

    // Sweep: each register holds its own index
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      checkOutput($sformatf("sweep_rd1_x%0d", i), RD1, 32'(i));
      checkOutput($sformatf("sweep_rd2_x%0d", 31 - i), RD2, 32'(31 - i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: XLEN, 32, data width of every register and data port.
REQ-002 Parameter: RESET_VAL, 32'h00000000, value loaded into registers x1..x31 on reset.
REQ-003 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: RESET  input  1  asynchronous, active-low reset; 0 resets immediately, independent of CLK.
REQ-005 Port: WE  input  1  write enable for the write port.
REQ-006 Port: A3  input  5  write address.
REQ-007 Port: WD  input  XLEN  write data.
REQ-008 Port: A1  input  5  read address, port 1.
REQ-009 Port: A2  input  5  read address, port 2.
REQ-010 Port: RD1  output  XLEN  read data, port 1.
REQ-011 Port: RD2  output  XLEN  read data, port 2.

Function
REQ-012 The block SHALL hold 32 registers x0..x31, each XLEN bits wide.
REQ-013 The write port SHALL be decoded to a 32-bit one-hot select from A3, gated by WE.
REQ-014 When RESET=1, WE=1 and A3!=0, register[A3] SHALL take WD on the rising CLK edge; all other registers SHALL hold.
REQ-015 A write with A3=0 SHALL be discarded; x0 SHALL read 0 at all times.
REQ-016 RD1/RD2 SHALL be combinational reads of register[A1]/register[A2]; latency is zero cycles, with no read enable.
REQ-017 Both read ports SHALL operate independently; A1=A2 SHALL return identical data on both ports.
REQ-018 Without bypass (REQ-024), a read of the address being written SHALL return the old value until the edge, then WD.
REQ-019 WE=0 SHALL leave all registers unchanged, regardless of A3 or WD.
REQ-020 X or Z on A3, WD or A1/A2 while WE=0 SHALL NOT corrupt stored state.

Reset
REQ-021 RESET=0 SHALL immediately force x1..x31 to RESET_VAL; x0 stays 0; RD1/RD2 reflect this combinationally.
REQ-022 Writes SHALL be ignored while RESET=0, including on the edge coincident with reset assertion.
REQ-023 After RESET rises, the first rising edge with WE=1 SHALL perform a normal write; there are no wait cycles.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN: when defined, if WE=1, A3!=0 and A1==A3 (respectively A2==A3), RD1 (RD2) SHALL equal WD in the same cycle (write-through).
REQ-025 Without REGFILE_BYPASS_EN, no forwarding logic SHALL exist and REQ-018 applies.
REQ-026 Bypass SHALL never forward when A3=0 or RESET=0.

Structure
REQ-027 Shared package riscv_pkg SHALL hold REG_COUNT=32, REG_ADDR_W=5, XLEN default, and a typedef reg_addr_t (5-bit).
REQ-028 The one-hot write-select decode SHALL be one sub-module, regfile_we_decode (5-bit address plus enable in, 32-bit one-hot out).
REQ-029 Storage SHALL be flops, not inferred RAM, so that async reset is legal.

Verification
REQ-030 Reset: drive RESET=0 mid-cycle, A1=5, A2=31 -> RD1=RD2=RESET_VAL before the next CLK edge; x0 reads 0.
REQ-031 Write/read: WE=1, A3=7, WD=32'hDEADBEEF, one edge, then A1=7 -> RD1=32'hDEADBEEF; every other register unchanged.
REQ-032 x0: WE=1, A3=0, WD=32'hFFFFFFFF, then A1=0, A2=0 -> RD1=RD2=0.
REQ-033 Same-cycle read of write target: A1=A3=12, WD=32'h00000055, old value 32'h11 -> RD1=32'h11 before the edge (32'h55 with REGFILE_BYPASS_EN), 32'h55 after.
REQ-034 Reset vs write: RESET falls coincident with a CLK edge while WE=1, A3=3, WD=32'hA5A5A5A5 -> x3=RESET_VAL; after release, a write to x3 lands on the first edge.
REQ-035 Sweep: write x1..x31 with value equal to the index, then read all pairs (A1=i, A2=31-i) -> each read data equals its index, x0=0.
